// File: rtl/demux_route_sched.sv
// Single-entry holding scheduler feeding a 1-to-2 demultiplexer.
// Each sink is protected by a saturating credit counter; the held word goes to one sink, chosen by key or round-robin.
module demux_route_sched #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_key,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    input  logic             credit_ret1,
    input  logic             credit_ret2,
    output logic [3:0]       cred1,
    output logic [3:0]       cred2,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic             rr_word_q, rr_word_d;
    logic [3:0]       cred1_q, cred1_d;
    logic [3:0]       cred2_q, cred2_d;
    logic             xfer1, xfer2;

    // A transfer and a return in the same cycle cancel; returns saturate at CRED_MAX.
    function automatic logic [3:0] next_cred(input logic [3:0] cur, input logic take,
                                             input logic give);
        next_cred = cur;
        if (take && !give)
            next_cred = cur - 4'd1;
        else if (give && !take && cur != CRED_MAX)
            next_cred = cur + 4'd1;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        rr_word_d = rr_word_q;

        out1_valid = (state_q == HOLD) && !sel_q && (cred1_q != 4'd0);
        out2_valid = (state_q == HOLD) &&  sel_q && (cred2_q != 4'd0);
        out1_data  = {WIDTH{out1_valid}} & hold_q;
        out2_data  = {WIDTH{out2_valid}} & hold_q;
        xfer1      = out1_valid && out1_ready;
        xfer2      = out2_valid && out2_ready;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d    = in_data;
                    sel_d     = mode ? rr_q : in_key;
                    rr_word_d = mode;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (xfer1 || xfer2) begin
                    state_d = IDLE;
                    if (rr_word_q)
                        rr_d = ~rr_q;
                end
            end
        endcase

        cred1_d = next_cred(cred1_q, xfer1, credit_ret1);
        cred2_d = next_cred(cred2_q, xfer2, credit_ret2);

        in_ready = (state_q == IDLE);
        busy     = (state_q == HOLD);
        cred1    = cred1_q;
        cred2    = cred2_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            // NOTE: the hold register is reset too, so out data is defined even if the gating is later removed.
            hold_q    <= '0;
            sel_q     <= 1'b0;
            rr_q      <= 1'b0;
            rr_word_q <= 1'b0;
            cred1_q   <= CRED_MAX;
            cred2_q   <= CRED_MAX;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            rr_word_q <= rr_word_d;
            cred1_q   <= cred1_d;
            cred2_q   <= cred2_d;
        end
    end

endmodule

// File: tb/tb_demux_route_sched.sv
// Self-checking bench for demux_route_sched: table-driven routing vectors plus hand-written credit,
// reset and backpressure sequences; a scoreboard queue is checked against every output handshake.
module tb_demux_route_sched;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             mode;
    logic [WIDTH-1:0] in_data;
    logic             in_key;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    logic             credit_ret1;
    logic             credit_ret2;
    logic [3:0]       cred1;
    logic [3:0]       cred2;
    logic             busy;

    always #5 clk = ~clk;

    demux_route_sched #(.WIDTH(WIDTH), .CREDITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .in_data     (in_data),
        .in_key      (in_key),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out1_data   (out1_data),
        .out1_valid  (out1_valid),
        .out1_ready  (out1_ready),
        .out2_data   (out2_data),
        .out2_valid  (out2_valid),
        .out2_ready  (out2_ready),
        .credit_ret1 (credit_ret1),
        .credit_ret2 (credit_ret2),
        .cred1       (cred1),
        .cred2       (cred2),
        .busy        (busy)
    );

    // sink: 0 = sink 1, 1 = sink 2
    typedef struct packed {
        logic       sink;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic       mode;
        logic       key;
        logic [7:0] data;
        logic       sink;
        logic [3:0] c1;
        logic [3:0] c2;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && ((out1_valid && out1_ready) || (out2_valid && out2_ready))) begin
            check("one_valid", 32'(out1_valid & out2_valid), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_sink", 32'(out2_valid), 32'(mon_e.sink));
                check("sb_data", 32'(out2_valid ? out2_data : out1_data), 32'(mon_e.data));
            end
        end
    end

    task automatic send(input logic m, input logic key, input logic [7:0] d, input logic sink);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready)
            check("send_ready_timeout", 32'd0, 32'd1);
        mode     = m;
        in_key   = key;
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back('{sink: sink, data: d});
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_key   = ~key;
        mode     = ~m;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 30) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || !in_ready)
            check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // mode, key, data, expected sink, expected cred1/cred2 after the transfer (from full credits)
        vecs[0] = '{1'b1, 1'b0, 8'h01, 1'b0, 4'd3, 4'd4};
        vecs[1] = '{1'b1, 1'b0, 8'h02, 1'b1, 4'd3, 4'd3};
        vecs[2] = '{1'b1, 1'b0, 8'h03, 1'b0, 4'd2, 4'd3};
        vecs[3] = '{1'b1, 1'b0, 8'h04, 1'b1, 4'd2, 4'd2};
        vecs[4] = '{1'b0, 1'b1, 8'h77, 1'b1, 4'd2, 4'd1};
        vecs[5] = '{1'b1, 1'b1, 8'h88, 1'b0, 4'd1, 4'd1};
        vecs[6] = '{1'b0, 1'b0, 8'h99, 1'b0, 4'd0, 4'd1};
        vecs[7] = '{1'b1, 1'b0, 8'hAB, 1'b1, 4'd0, 4'd0};

        mode = 1'b0; in_data = '0; in_key = 1'b0; in_valid = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0; credit_ret1 = 1'b0; credit_ret2 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out2_valid", 32'(out2_valid), 32'd0);
        check("rst_out1_data", 32'(out1_data), 32'd0);
        check("rst_out2_data", 32'(out2_data), 32'd0);
        check("rst_cred1", 32'(cred1), 32'd4);
        check("rst_cred2", 32'(cred2), 32'd4);

        // Key mode, one-cycle latency and AND-gated data
        send(1'b0, 1'b0, 8'hA5, 1'b0);
        check("key_out1_valid", 32'(out1_valid), 32'd1);
        check("key_out1_data", 32'(out1_data), 32'hA5);
        check("key_out2_valid", 32'(out2_valid), 32'd0);
        check("key_out2_data", 32'(out2_data), 32'd0);
        check("key_busy", 32'(busy), 32'd1);
        check("key_in_ready", 32'(in_ready), 32'd0);
        out1_ready = 1'b1;
        tick();
        check("key_cred1", 32'(cred1), 32'd3);
        check("key_in_ready_back", 32'(in_ready), 32'd1);

        // Routing table: round-robin, key mode, rr pointer persistence across key words
        do_reset();
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].mode, vecs[i].key, vecs[i].data, vecs[i].sink);
            drain();
            check($sformatf("vec%0d_cred1", i), 32'(cred1), 32'(vecs[i].c1));
            check($sformatf("vec%0d_cred2", i), 32'(cred2), 32'(vecs[i].c2));
        end

        // Credit stall on sink 1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, 8'(8'h10 + i), 1'b0);
            drain();
        end
        check("stall_cred1_zero", 32'(cred1), 32'd0);
        send(1'b0, 1'b0, 8'h55, 1'b0);
        tick();
        tick();
        check("stall_out1_valid", 32'(out1_valid), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        credit_ret1 = 1'b1;
        tick();
        credit_ret1 = 1'b0;
        check("stall_ret_cred1", 32'(cred1), 32'd1);
        check("stall_ret_valid", 32'(out1_valid), 32'd1);
        check("stall_ret_data", 32'(out1_data), 32'h55);
        tick();
        check("stall_done_cred1", 32'(cred1), 32'd0);
        check("stall_done_ready", 32'(in_ready), 32'd1);
        check("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous transfer and return; saturation of returns
        do_reset();
        send(1'b0, 1'b1, 8'h21, 1'b1);
        drain();
        send(1'b0, 1'b1, 8'h22, 1'b1);
        drain();
        check("sim_cred2_pre", 32'(cred2), 32'd2);
        out2_ready = 1'b0;
        send(1'b0, 1'b1, 8'h23, 1'b1);
        check("sim_out2_valid", 32'(out2_valid), 32'd1);
        out2_ready  = 1'b1;
        credit_ret2 = 1'b1;
        tick();
        credit_ret2 = 1'b0;
        check("sim_cred2_same", 32'(cred2), 32'd2);
        check("sim_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            credit_ret1 = 1'b1;
            tick();
            credit_ret1 = 1'b0;
            tick();
        end
        check("sat_cred1", 32'(cred1), 32'd4);
        for (int i = 0; i < 3; i++) begin
            credit_ret2 = 1'b1;
            tick();
            credit_ret2 = 1'b0;
        end
        check("sat_cred2", 32'(cred2), 32'd4);

        // Reset mid-operation discards the held word
        do_reset();
        out2_ready = 1'b0;
        send(1'b0, 1'b1, 8'h3C, 1'b1);
        check("mid_out2_valid", 32'(out2_valid), 32'd1);
        check("mid_out2_data", 32'(out2_data), 32'h3C);
        do_reset();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_out2_valid_low", 32'(out2_valid), 32'd0);
        check("mid_cred1", 32'(cred1), 32'd4);
        check("mid_cred2", 32'(cred2), 32'd4);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        send(1'b1, 1'b1, 8'h5A, 1'b0);
        drain();
        check("mid_rr_cred1", 32'(cred1), 32'd3);

        // Backpressure: held word stable, no new capture
        out1_ready = 1'b0;
        send(1'b0, 1'b0, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_key   = 1'b1;
            in_data  = 8'($urandom);
            tick();
            check($sformatf("bp%0d_data", i), 32'(out1_data), 32'h11);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        drain();
        check("bp_cred1", 32'(cred1), 32'd2);
        check("bp_cred2", 32'(cred2), 32'd4);
        tick();
        tick();
        tick();
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
